// File: rtl/param_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared types and helpers for the param_updown_counter slice.
//   - cnt_width(max) : number of bits needed to hold 0..max
//   - cnt_mode_e     : boundary behaviour (wrap or saturate)
//   - default modulus and prescale ratio used by the interface and top
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int DEFAULT_MAX_COUNT = 255;
  localparam int DEFAULT_PRESCALE  = 4;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // A modulus below 1 is illegal; returning 1 keeps widths sane regardless.
  function automatic int cnt_width(input int max);
    if (max < 1) begin
      return 1;
    end
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// ---------------------------------------------------------------------------
// param_updown_counter_if
//   Control/status bundle of the up/down counter.
//   master : drives en, up_dn, load, load_val, clr_ovf; observes count, tc, ovf
//   slave  : the counter itself
//   MAX_COUNT must match the MAX_COUNT of the counter it is connected to.
// ---------------------------------------------------------------------------
interface param_updown_counter_if
  import counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
);

  localparam int W = cnt_width(MAX_COUNT);

  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;

  modport master (
    output en, up_dn, load, load_val, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_ovf,
    output count, tc, ovf
  );

endinterface

// File: rtl/param_updown_counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
//   Divides the count enable by PRESCALE. The phase counter advances on each
//   enabled cycle through 0..PRESCALE-1; tick is high on the enabled cycle in
//   which the phase sits at PRESCALE-1, so the parent steps in that same cycle.
//   Ports:
//     clk    in  clock, posedge
//     rst_n  in  synchronous reset, active-low (phase -> 0)
//     en     in  enable; en=0 freezes the phase
//     clr    in  synchronous phase restart (phase -> 0), beats en
//     tick   out combinational divided enable
//   Only instantiated when PARAM_COUNTER_PRESCALE_EN is defined.
// ---------------------------------------------------------------------------
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int PW = (PS > 1) ? $clog2(PS) : 1;
  localparam logic [PW-1:0] LAST = PW'(PS - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase;
  logic          at_last;

  assign at_last = (phase == LAST);
  assign tick    = en && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= at_last ? '0 : phase + ONE;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//   Up/down counter modulo MAX_COUNT+1 with enable, synchronous load (clamped
//   to MAX_COUNT), wrap or saturate at the boundary, terminal-count strobe and
//   a sticky overflow/underflow flag. Used as the timing primitive for timers,
//   baud dividers and watchdogs.
//   Parameters:
//     MAX_COUNT  highest count value (>= 1)
//     SATURATE   0 = wrap at the boundary, 1 = hold at the boundary
//     PRESCALE   enable divide ratio, only with PARAM_COUNTER_PRESCALE_EN
//   Ports:
//     clk    in  clock, posedge
//     rst_n  in  synchronous reset, active-low
//     bus    slave modport of param_updown_counter_if:
//              en, up_dn, load, load_val, clr_ovf in; count, tc, ovf out
//   Build option:
//     PARAM_COUNTER_PRESCALE_EN  defined -> count steps once per PRESCALE
//                                enabled cycles; load restarts the phase
// ---------------------------------------------------------------------------
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = DEFAULT_PRESCALE
) (
  input logic                  clk,
  input logic                  rst_n,
  param_updown_counter_if.slave bus
);

  localparam int W = cnt_width(MAX_COUNT);
  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] count_q;
  logic         ovf_q;
  logic         step;
  logic         at_bound;
  logic         tc_int;
  logic [W-1:0] load_clamped;
  logic [W-1:0] count_stepped;

`ifdef PARAM_COUNTER_PRESCALE_EN
  logic tick;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick)
  );

  // tick already carries en
  assign step = tick;
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE < 1);
  assign step = bus.en;
`endif

  // Boundary depends only on registered count and up_dn, so load_val never
  // reaches tc combinationally.
  assign at_bound = bus.up_dn ? (count_q == MAX_V) : (count_q == '0);
  assign tc_int   = step && at_bound;

  // When MAX_COUNT+1 is a power of two this compare is never true and the
  // clamp folds away.
  assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

  always_comb begin
    count_stepped = count_q;
    if (at_bound) begin
      if (MODE == CNT_WRAP) begin
        count_stepped = bus.up_dn ? '0 : MAX_V;
      end
    end else if (bus.up_dn) begin
      count_stepped = count_q + ONE;
    end else begin
      count_stepped = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.load) begin
        count_q <= load_clamped;
      end else if (step) begin
        count_q <= count_stepped;
      end

      // Setting beats clearing; a load in the same cycle suppresses the set.
      if (tc_int && !bus.load) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_int;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n0;
  logic rst_n1;
  int   cyc;
  int   tests;
  int   fails;
  exp_t q[$];
  exp_t e;
  logic [3:0] ac;
  logic       at;
  logic       ao;

  param_updown_counter_if #(.MAX_COUNT(9)) b0 ();
  param_updown_counter_if #(.MAX_COUNT(9)) b1 ();

  param_updown_counter #(.MAX_COUNT(9), .SATURATE(0), .PRESCALE(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .bus   (b0)
  );

  param_updown_counter #(.MAX_COUNT(9), .SATURATE(1), .PRESCALE(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each queued expectation at the falling edge of the
  // cycle it belongs to.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      if (e.sel == 0) begin
        ac = b0.count; at = b0.tc; ao = b0.ovf;
      end else begin
        ac = b1.count; at = b1.tc; ao = b1.ovf;
      end
      tests = tests + 3;
      if (ac !== e.cnt) begin
        fails = fails + 1;
        $display("FAIL %s dut%0d count: got %0d expected %0d", e.nm, e.sel, ac, e.cnt);
      end
      if (at !== e.tc) begin
        fails = fails + 1;
        $display("FAIL %s dut%0d tc: got %b expected %b", e.nm, e.sel, at, e.tc);
      end
      if (ao !== e.ovf) begin
        fails = fails + 1;
        $display("FAIL %s dut%0d ovf: got %b expected %b", e.nm, e.sel, ao, e.ovf);
      end
    end
  end

  // Drives one cycle of inputs on the selected counter (the other idles) and
  // queues the state expected to be visible during that cycle.
  task automatic step(input int sel, input logic rst, input logic en,
                      input logic up, input logic ld, input logic [3:0] lv,
                      input logic clr, input bit chk, input logic [3:0] ec,
                      input logic etc, input logic eovf, input string nm);
    exp_t x;
    @(posedge clk);
    #2;
    rst_n0 = 1'b1; b0.en = 1'b0; b0.up_dn = 1'b0; b0.load = 1'b0;
    b0.load_val = 4'd0; b0.clr_ovf = 1'b0;
    rst_n1 = 1'b1; b1.en = 1'b0; b1.up_dn = 1'b0; b1.load = 1'b0;
    b1.load_val = 4'd0; b1.clr_ovf = 1'b0;
    if (sel == 0) begin
      rst_n0 = rst; b0.en = en; b0.up_dn = up; b0.load = ld;
      b0.load_val = lv; b0.clr_ovf = clr;
    end else begin
      rst_n1 = rst; b1.en = en; b1.up_dn = up; b1.load = ld;
      b1.load_val = lv; b1.clr_ovf = clr;
    end
    if (chk) begin
      x.cyc = cyc; x.sel = sel; x.cnt = ec; x.tc = etc; x.ovf = eovf; x.nm = nm;
      q.push_back(x);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    b0.en = 1'b0; b0.up_dn = 1'b0; b0.load = 1'b0; b0.load_val = 4'd0; b0.clr_ovf = 1'b0;
    b1.en = 1'b0; b1.up_dn = 1'b0; b1.load = 1'b0; b1.load_val = 4'd0; b1.clr_ovf = 1'b0;

    //   sel rst en up ld lv clr chk  cnt tc ovf
    step(0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, "reset");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "rst_state");
    step(1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "rst_state");
    step(0, 1, 0, 0, 1, 4'd5, 0, 1, 4'd0, 0, 0, "pre_load5");
    step(0, 0, 0, 0, 1, 4'd7, 0, 1, 4'd5, 0, 0, "load5");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "rst_beats_load");

`ifdef PARAM_COUNTER_PRESCALE_EN
    step(0, 1, 0, 0, 1, 4'd12, 0, 1, 4'd0, 0, 0, "pre_clamp");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "load_clamp");
    step(0, 0, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "pre_rst");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_ph0");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_ph1");
    step(0, 1, 0, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_gap0");
    step(0, 1, 0, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_gap1");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_ph2");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ps_ph3");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd1, 0, 0, "ps_step1");
    step(0, 1, 1, 1, 1, 4'd5, 0, 1, 4'd1, 0, 0, "ps_load");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd5, 0, 0, "ps_restart0");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd5, 0, 0, "ps_restart1");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd5, 0, 0, "ps_restart2");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd5, 0, 0, "ps_restart3");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd6, 0, 0, "ps_step6");
    step(0, 1, 0, 0, 1, 4'd9, 0, 1, 4'd6, 0, 0, "ps_load9");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 0, 0, "ps_tc_ph0");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 0, 0, "ps_tc_ph1");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 0, 0, "ps_tc_ph2");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 0, "ps_tc_ph3");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 1, "ps_wrap");
`else
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'(i), (i == 9), 0, "up_wrap");
    end
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 1, "wrap_ovf");
    step(0, 1, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, "clr_req");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "ovf_cleared");
    step(0, 1, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 0, "down_tc");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 1, "down_wrap");
    step(0, 1, 0, 0, 0, 4'd0, 1, 1, 4'd9, 0, 1, "clr_req2");
    step(0, 1, 1, 1, 0, 4'd0, 1, 1, 4'd9, 1, 0, "tc_with_clr");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 1, "set_beats_clr");
    step(0, 1, 0, 0, 1, 4'd12, 1, 1, 4'd0, 0, 1, "pre_clamp");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "load_clamp");
    step(0, 1, 1, 1, 1, 4'd3, 0, 1, 4'd9, 1, 0, "load_vs_tc");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd3, 0, 0, "load_wins");
    step(0, 1, 0, 0, 1, 4'd9, 0, 1, 4'd3, 0, 0, "pre_load9");
    step(0, 1, 0, 1, 0, 4'd0, 0, 1, 4'd9, 0, 0, "en0_tc");
    step(0, 1, 1, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "dir_dn_at_max");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd8, 0, 0, "dir_up");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 0, "dir_up_back");
    step(0, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 0, "pre_ovf");
    step(0, 0, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 1, "ovf_before_rst");
    step(0, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "rst_clears_ovf");

    step(1, 1, 0, 0, 1, 4'd2, 0, 1, 4'd0, 0, 0, "sat_load2");
    step(1, 1, 1, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, "sat_dn2");
    step(1, 1, 1, 0, 0, 4'd0, 0, 1, 4'd1, 0, 0, "sat_dn1");
    step(1, 1, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 0, "sat_dn0a");
    step(1, 1, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "sat_dn0b");
    step(1, 1, 1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, "sat_dn0c");
    step(1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 1, "sat_hold0");
    step(1, 1, 0, 0, 1, 4'd9, 1, 1, 4'd0, 0, 1, "sat_load9");
    step(1, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 0, "sat_up_a");
    step(1, 1, 1, 1, 0, 4'd0, 0, 1, 4'd9, 1, 1, "sat_up_b");
    step(1, 1, 0, 0, 0, 4'd0, 0, 1, 4'd9, 0, 1, "sat_hold_max");
`endif

    step(0, 1, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, "idle");
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
